// File: rtl/melody_seq.sv
// -----------------------------------------------------------------------------
// melody_seq
//   Note sequencer that walks an internal song table and drives the tone
//   generator. Each table entry sounds for (dur*BEAT_TICKS - GAP_TICKS) cycles
//   and is then followed by GAP_TICKS silent cycles for articulation. Rests
//   (freq 0) keep enable low and hold the last nonzero rate, so the
//   downstream divider never receives 0.
//
// Ports
//   clk       in   1   system clock
//   reset     in   1   synchronous, active-high reset
//   play      in   1   start the song from entry 0 (only honoured when idle)
//   stop      in   1   abort playback (honoured in every state)
//   rate      out  23  note frequency in Hz to the tone generator, never 0
//   enable    out  1   note sounding
//   busy      out  1   sequencer not idle
//   done      out  1   one-cycle pulse when the end marker is reached
//   note_idx  out  5   current song table index
//
// Configuration
//   MELODY_SEQ_LOOP_EN  when defined, the end marker restarts the song at
//                       entry 0 with no done pulse; playback continues until
//                       stop or reset.
// -----------------------------------------------------------------------------
module melody_seq #(
  parameter int BEAT_TICKS = 2500000,
  parameter int GAP_TICKS  = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic        stop,
  output logic [22:0] rate,
  output logic        enable,
  output logic        busy,
  output logic        done,
  output logic [4:0]  note_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NOTE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Song table: [15:4] frequency in Hz, [3:0] duration in beats (0 = end).
  function automatic logic [15:0] song_rom(input logic [4:0] idx);
    logic [15:0] entry;
    case (idx)
      5'd0:    entry = {12'd440, 4'd1};
      5'd1:    entry = {12'd0,   4'd1};
      5'd2:    entry = {12'd523, 4'd2};
      5'd3:    entry = {12'd0,   4'd0};
      default: entry = {12'd0,   4'd0};
    endcase
    return entry;
  endfunction

  // A rest keeps the previous rate so the tone generator never divides by 0.
  function automatic logic [22:0] pick_rate(input logic [11:0] freq,
                                            input logic [22:0] cur_rate);
    logic [22:0] r;
    if (freq != 12'd0) begin
      r = {11'd0, freq};
    end else begin
      r = cur_rate;
    end
    return r;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [25:0] cnt_r;
  logic [25:0] cnt_nxt_s;
  logic [3:0]  dur_r;
  logic [3:0]  dur_nxt_s;
  logic [22:0] rate_r;
  logic [22:0] rate_nxt_s;
  logic        enable_r;
  logic        enable_nxt_s;
  logic        busy_r;
  logic        done_r;
  logic        done_nxt_s;
  logic [4:0]  idx_r;
  logic [4:0]  idx_nxt_s;

  logic [15:0] entry0_s;
  logic [15:0] next_entry_s;
  logic [4:0]  idx_inc_s;
  logic [25:0] note_last_s;
  logic [25:0] gap_last_s;
  logic        note_end_s;
  logic        gap_end_s;

  assign idx_inc_s    = idx_r + 5'd1;
  assign entry0_s     = song_rom(5'd0);
  assign next_entry_s = song_rom(idx_inc_s);
  // Last counter value of the sounding part of the current entry.
  assign note_last_s  = 26'(dur_r) * 26'(BEAT_TICKS) - 26'(GAP_TICKS) - 26'd1;
  assign gap_last_s   = 26'(GAP_TICKS) - 26'd1;
  assign note_end_s   = (cnt_r == note_last_s);
  assign gap_end_s    = (cnt_r == gap_last_s);

  assign rate     = rate_r;
  assign enable   = enable_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign note_idx = idx_r;

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 26'd0;
      dur_r    <= 4'd0;
      rate_r   <= 23'd440;
      enable_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      idx_r    <= 5'd0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      dur_r    <= dur_nxt_s;
      rate_r   <= rate_nxt_s;
      enable_r <= enable_nxt_s;
      busy_r   <= (state_nxt_s != ST_IDLE);
      done_r   <= done_nxt_s;
      idx_r    <= idx_nxt_s;
    end
  end

  // Next-state decode; stop overrides every other event.
  always_comb begin
    state_nxt_s = state_r;
    if (stop) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (play && (entry0_s[3:0] != 4'd0)) begin
            state_nxt_s = ST_NOTE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_NOTE: begin
          if (note_end_s) begin
            state_nxt_s = ST_GAP;
          end else begin
            state_nxt_s = ST_NOTE;
          end
        end
        ST_GAP: begin
          if (!gap_end_s) begin
            state_nxt_s = ST_GAP;
          end else if (next_entry_s[3:0] != 4'd0) begin
            state_nxt_s = ST_NOTE;
          end else begin
`ifdef MELODY_SEQ_LOOP_EN
            if (entry0_s[3:0] != 4'd0) begin
              state_nxt_s = ST_NOTE;
            end else begin
              state_nxt_s = ST_IDLE;
            end
`else
            state_nxt_s = ST_IDLE;
`endif
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Next values of counter, entry fields and outputs.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    dur_nxt_s    = dur_r;
    rate_nxt_s   = rate_r;
    enable_nxt_s = enable_r;
    done_nxt_s   = 1'b0;
    idx_nxt_s    = idx_r;
    if (stop) begin
      cnt_nxt_s    = 26'd0;
      enable_nxt_s = 1'b0;
      idx_nxt_s    = 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          enable_nxt_s = 1'b0;
          if (play) begin
            // Entry 0 being the end marker ends the song immediately.
            cnt_nxt_s    = 26'd0;
            idx_nxt_s    = 5'd0;
            dur_nxt_s    = entry0_s[3:0];
            rate_nxt_s   = pick_rate(entry0_s[15:4], rate_r);
            enable_nxt_s = (entry0_s[3:0] != 4'd0) && (entry0_s[15:4] != 12'd0);
            done_nxt_s   = (entry0_s[3:0] == 4'd0);
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        ST_NOTE: begin
          if (note_end_s) begin
            cnt_nxt_s    = 26'd0;
            enable_nxt_s = 1'b0;
          end else begin
            cnt_nxt_s = cnt_r + 26'd1;
          end
        end
        ST_GAP: begin
          enable_nxt_s = 1'b0;
          if (!gap_end_s) begin
            cnt_nxt_s = cnt_r + 26'd1;
          end else if (next_entry_s[3:0] != 4'd0) begin
            cnt_nxt_s    = 26'd0;
            idx_nxt_s    = idx_inc_s;
            dur_nxt_s    = next_entry_s[3:0];
            rate_nxt_s   = pick_rate(next_entry_s[15:4], rate_r);
            enable_nxt_s = (next_entry_s[15:4] != 12'd0);
          end else begin
            cnt_nxt_s = 26'd0;
`ifdef MELODY_SEQ_LOOP_EN
            idx_nxt_s = 5'd0;
            if (entry0_s[3:0] != 4'd0) begin
              dur_nxt_s    = entry0_s[3:0];
              rate_nxt_s   = pick_rate(entry0_s[15:4], rate_r);
              enable_nxt_s = (entry0_s[15:4] != 12'd0);
            end else begin
              dur_nxt_s = dur_r;
            end
`else
            idx_nxt_s  = idx_inc_s;
            done_nxt_s = 1'b1;
`endif
          end
        end
        default: begin
          cnt_nxt_s    = 26'd0;
          enable_nxt_s = 1'b0;
          idx_nxt_s    = 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_melody_seq.sv
// -----------------------------------------------------------------------------
// tb_melody_seq
//   Scoreboard bench for melody_seq with BEAT_TICKS=20, GAP_TICKS=4. Stimulus
//   pushes per-cycle expectations (hand-derived from the song timing) into a
//   queue; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_melody_seq;

  logic        clk;
  logic        reset;
  logic        play;
  logic        stop;
  logic [22:0] rate;
  logic        enable;
  logic        busy;
  logic        done;
  logic [4:0]  note_idx;

  int cyc;
  int total;
  int bad;

  typedef struct {
    int          cyc;
    string       tag;
    logic [22:0] rate;
    logic        en;
    logic        busy;
    logic        done;
    logic [4:0]  idx;
    logic        chk_rate;
    logic        chk_idx;
  } exp_t;

  exp_t exp_q[$];

  melody_seq #(.BEAT_TICKS(20), .GAP_TICKS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .play     (play),
    .stop     (stop),
    .rate     (rate),
    .enable   (enable),
    .busy     (busy),
    .done     (done),
    .note_idx (note_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input string tag, input int r, input bit en,
                      input bit b, input bit d, input int idx,
                      input bit cr, input bit ci);
    exp_t e;
    e.cyc = c; e.tag = tag; e.rate = 23'(r); e.en = en; e.busy = b;
    e.done = d; e.idx = 5'(idx); e.chk_rate = cr; e.chk_idx = ci;
    exp_q.push_back(e);
  endtask

  // Expected outputs for cycles t+1..t+kmax of the default song.
  task automatic push_song_part(input int t, input string tag, input int kmax);
    for (int k = 1; k <= kmax; k++) begin
      if (k <= 16)      push(t + k, tag, 440, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1);
      else if (k <= 20) push(t + k, tag, 440, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
      else if (k <= 40) push(t + k, tag, 440, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b1);
      else if (k <= 76) push(t + k, tag, 523, 1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b1);
      else              push(t + k, tag, 523, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b1);
    end
  endtask

  task automatic push_song(input int t, input string tag);
    push_song_part(t, tag, 80);
`ifdef MELODY_SEQ_LOOP_EN
    push(t + 81, {tag, "_loop"}, 440, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1);
    push(t + 82, {tag, "_loop"}, 440, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1);
`else
    push(t + 81, {tag, "_done"}, 523, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    push(t + 82, {tag, "_after"}, 523, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
`endif
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Bring the song to a quiet idle state after the tail expectations.
  task automatic finish_song(input int t);
`ifdef MELODY_SEQ_LOOP_EN
    at_cycle(t + 82);
    stop = 1'b1;
    push(t + 83, "loop_stop", 440, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    @(negedge clk);
    stop = 1'b0;
    at_cycle(t + 85);
`else
    at_cycle(t + 84);
`endif
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s stale expectation for cycle %0d seen at cycle %0d", e.tag, e.cyc, cyc);
      end else if ((e.chk_rate && rate !== e.rate) || enable !== e.en ||
                   busy !== e.busy || done !== e.done ||
                   (e.chk_idx && note_idx !== e.idx)) begin
        bad++;
        $display("FAIL %s cyc=%0d got rate=%0d en=%0b busy=%0b done=%0b idx=%0d want rate=%0d(chk %0b) en=%0b busy=%0b done=%0b idx=%0d(chk %0b)",
                 e.tag, cyc, rate, enable, busy, done, note_idx,
                 e.rate, e.chk_rate, e.en, e.busy, e.done, e.idx, e.chk_idx);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    play  = 1'b0;
    stop  = 1'b0;

    // Reset held for two edges, then check the idle state.
    @(negedge clk);
    push(cyc + 1, "reset", 440, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    push(cyc + 2, "reset_rel", 440, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    at_cycle(cyc + 2);

    // Full song from a single play pulse.
    t = cyc;
    play = 1'b1;
    push_song(t, "song");
    @(negedge clk);
    play = 1'b0;
    finish_song(t);

    // Stop during the rest entry.
    t = cyc;
    play = 1'b1;
    push_song_part(t, "stop_pre", 30);
    for (int k = 31; k <= 34; k++)
      push(t + k, "stop_idle", 440, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    @(negedge clk);
    play = 1'b0;
    at_cycle(t + 30);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    at_cycle(t + 36);

    // play held high for the first ten cycles: no restart.
    t = cyc;
    play = 1'b1;
    push_song(t, "play_held");
    at_cycle(t + 11);
    play = 1'b0;
    finish_song(t);

    // stop and play together from idle: stays idle.
    t = cyc;
    play = 1'b1;
    stop = 1'b1;
    for (int k = 1; k <= 4; k++)
      push(t + k, "stop_play", 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);
    play = 1'b0;
    stop = 1'b0;
    at_cycle(t + 6);

    // Reset in the middle of the third entry, then a fresh play.
    t = cyc;
    play = 1'b1;
    push_song_part(t, "rst_pre", 50);
    push(t + 51, "mid_reset", 440, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    push(t + 52, "mid_reset_idle", 440, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    @(negedge clk);
    play = 1'b0;
    at_cycle(t + 50);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    at_cycle(t + 53);
    t = cyc;
    play = 1'b1;
    push_song(t, "replay");
    @(negedge clk);
    play = 1'b0;
    finish_song(t);

    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL %s expectation for cycle %0d never checked", e.tag, e.cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
